// File: rtl/multi_port_stream_compactor_if.sv
// Handshake bundle between a sparse-lane producer, the compactor and the
// FIFO enqueue port; master is the environment side, slave is the compactor.
interface multi_port_stream_compactor_if #(
   parameter int unsigned InWidth   = 4,
   parameter int unsigned OutWidth  = 2,
   parameter int unsigned DataWidth = 32
) ();
   logic                          in_vld_i;
   logic [InWidth-1:0]            in_mask_i;
   logic [InWidth*DataWidth-1:0]  in_payload_i;
   logic                          in_rdy_o;
   logic [OutWidth-1:0]           out_vld_o;
   logic [OutWidth*DataWidth-1:0] out_payload_o;
   logic [OutWidth-1:0]           out_rdy_i;
   logic                          flush_i;

   modport master (
      output in_vld_i, in_mask_i, in_payload_i, out_rdy_i, flush_i,
      input  in_rdy_o, out_vld_o, out_payload_o
   );

   modport slave (
      input  in_vld_i, in_mask_i, in_payload_i, out_rdy_i, flush_i,
      output in_rdy_o, out_vld_o, out_payload_o
   );
endinterface

// File: rtl/multi_port_stream_compactor.sv
// Packs the valid lanes of sparse input beats into a circular buffer and
// presents the oldest entries as a dense, lane-0-aligned enqueue group.
module multi_port_stream_compactor #(
   parameter int unsigned InWidth   = 4,
   parameter int unsigned OutWidth  = 2,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned BufDepth  = 8
) (
   input  logic                        clk,
   input  logic                        rstn,
   multi_port_stream_compactor_if.slave bus
);
   localparam int unsigned PtrW = $clog2(BufDepth);
   localparam int unsigned CntW = $clog2(BufDepth + 1);
   localparam logic [CntW-1:0] DepthC   = CntW'(BufDepth);
   localparam logic [CntW-1:0] InWidthC = CntW'(InWidth);

   logic [PtrW-1:0]               head_q;
   logic [PtrW-1:0]               tail_q;
   logic [CntW-1:0]               cnt_q;
   logic [DataWidth-1:0]          mem [BufDepth];

   logic [CntW-1:0]               lane_off [InWidth];
   logic [CntW-1:0]               in_cnt;
   logic [CntW-1:0]               drain_cnt;
   logic                          drain_run;
   logic                          in_rdy;
   logic                          in_fire;
   logic [OutWidth-1:0]           out_vld;
   logic [OutWidth-1:0]           out_fire;
   logic [OutWidth*DataWidth-1:0] out_payload;

   // Free-space check only; a same-cycle drain is deliberately not credited.
   assign in_rdy   = (DepthC - cnt_q) >= InWidthC;
   assign in_fire  = bus.in_vld_i & in_rdy;
   assign out_fire = out_vld & bus.out_rdy_i;

   assign bus.in_rdy_o      = in_rdy;
   assign bus.out_vld_o     = out_vld;
   assign bus.out_payload_o = out_payload;

   // Each set lane lands at tail + (number of set lanes below it).
   always_comb begin : compact
      in_cnt = '0;
      for (int unsigned i = 0; i < InWidth; i++) begin
         lane_off[i] = in_cnt;
         if (bus.in_mask_i[i]) in_cnt = in_cnt + CntW'(1);
      end
   end

   always_comb begin : drain
      drain_cnt = '0;
      drain_run = 1'b1;
      for (int unsigned i = 0; i < OutWidth; i++) begin
         if (drain_run && out_fire[i]) drain_cnt = drain_cnt + CntW'(1);
         else                          drain_run = 1'b0;
      end
   end

   always_comb begin : present
      out_vld     = '0;
      out_payload = '0;
      for (int unsigned i = 0; i < OutWidth; i++) begin
         out_vld[i] = CntW'(i) < cnt_q;
         out_payload[i*DataWidth +: DataWidth] = mem[head_q + PtrW'(i)];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (bus.flush_i) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_q + drain_cnt[PtrW-1:0];
         if (in_fire) tail_q <= tail_q + in_cnt[PtrW-1:0];
         cnt_q  <= cnt_q + (in_fire ? in_cnt : '0) - drain_cnt;
      end
   end

   always_ff @(posedge clk) begin : store
      if (in_fire && !bus.flush_i) begin
         for (int unsigned i = 0; i < InWidth; i++) begin
            if (bus.in_mask_i[i])
               mem[tail_q + lane_off[i][PtrW-1:0]] <= bus.in_payload_i[i*DataWidth +: DataWidth];
         end
      end
   end
endmodule

// File: tb/tb_multi_port_stream_compactor.sv
// Scoreboard bench for multi_port_stream_compactor: a negedge monitor keeps a
// reference queue of accepted lanes and compares every output cycle.
module tb_multi_port_stream_compactor;
   localparam int unsigned InW   = 4;
   localparam int unsigned OutW  = 2;
   localparam int unsigned DW    = 32;
   localparam int unsigned Depth = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] seq = 32'h0000_1000;

   always #5 clk = ~clk;

   multi_port_stream_compactor_if #(.InWidth(InW), .OutWidth(OutW), .DataWidth(DW)) bus ();

   multi_port_stream_compactor #(
      .InWidth(InW), .OutWidth(OutW), .DataWidth(DW), .BufDepth(Depth)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Reference model: compare against the queue, then apply this cycle's edge.
   always @(negedge clk) begin : monitor
      int unsigned n;
      int unsigned d;
      logic        exp_rdy;
      logic [OutW-1:0] exp_vld;
      logic        run;
      if (!rstn) sb.delete();
      n = sb.size();
      exp_rdy = (Depth - n) >= InW;
      exp_vld = '0;
      for (int l = 0; l < OutW; l++) if (l < n) exp_vld[l] = 1'b1;
      checks++;
      if (bus.in_rdy_o !== exp_rdy) begin
         errors++;
         $display("FAIL sb_in_rdy t=%0t got=%b exp=%b", $time, bus.in_rdy_o, exp_rdy);
      end
      checks++;
      if (bus.out_vld_o !== exp_vld) begin
         errors++;
         $display("FAIL sb_out_vld t=%0t got=%b exp=%b", $time, bus.out_vld_o, exp_vld);
      end
      for (int l = 0; l < OutW; l++) begin
         if (l < n) begin
            checks++;
            if (bus.out_payload_o[l*DW +: DW] !== sb[l]) begin
               errors++;
               $display("FAIL sb_lane%0d t=%0t got=%h exp=%h", l, $time,
                        bus.out_payload_o[l*DW +: DW], sb[l]);
            end
         end
      end
      checks++;
      if (dut.cnt_q !== 4'(n)) begin
         errors++;
         $display("FAIL sb_cnt t=%0t got=%0d exp=%0d", $time, dut.cnt_q, n);
      end
      if (rstn) begin
         if (bus.flush_i) begin
            sb.delete();
         end else begin
            d = 0;
            run = 1'b1;
            for (int l = 0; l < OutW; l++) begin
               if (run && exp_vld[l] && bus.out_rdy_i[l]) d++;
               else run = 1'b0;
            end
            for (int unsigned k = 0; k < d; k++) void'(sb.pop_front());
            if (bus.in_vld_i && exp_rdy)
               for (int l = 0; l < InW; l++)
                  if (bus.in_mask_i[l]) sb.push_back(bus.in_payload_i[l*DW +: DW]);
         end
      end
   end

   // Caller sits at posedge+1; inputs are applied and held through the next edge.
   task automatic drive(input logic vld, input logic [InW-1:0] mask,
                        input logic [InW*DW-1:0] pl, input logic [OutW-1:0] rdy,
                        input logic fl);
      bus.in_vld_i     = vld;
      bus.in_mask_i    = mask;
      bus.in_payload_i = pl;
      bus.out_rdy_i    = rdy;
      bus.flush_i      = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic fresh(output logic [InW*DW-1:0] pl);
      for (int l = 0; l < InW; l++) begin
         pl[l*DW +: DW] = seq;
         seq = seq + 32'd1;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.in_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got=%b exp=1", bus.in_rdy_o); end
      checks++;
      if (bus.out_vld_o !== 2'b00) begin errors++; $display("FAIL reset_out_vld got=%b exp=00", bus.out_vld_o); end
      checks++;
      if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt_q); end
      rstn = 1'b1;
   endtask

   task automatic test_pass_through();
      logic [InW*DW-1:0] pl;
      pl = {32'hA3, 32'hDEAD_0002, 32'hA1, 32'hDEAD_0000};
      drive(1'b1, 4'b1010, pl, 2'b11, 1'b0);
      checks++;
      if (bus.out_vld_o !== 2'b11) begin errors++; $display("FAIL pass_vld got=%b exp=11", bus.out_vld_o); end
      checks++;
      if (bus.out_payload_o[31:0] !== 32'hA1) begin errors++; $display("FAIL pass_lane0 got=%h exp=a1", bus.out_payload_o[31:0]); end
      checks++;
      if (bus.out_payload_o[63:32] !== 32'hA3) begin errors++; $display("FAIL pass_lane1 got=%h exp=a3", bus.out_payload_o[63:32]); end
      drive(1'b0, '0, '0, 2'b11, 1'b0);
      checks++;
      if (bus.out_vld_o !== 2'b00) begin errors++; $display("FAIL pass_empty got=%b exp=00", bus.out_vld_o); end
   endtask

   task automatic test_fill_to_stall();
      logic [InW*DW-1:0] pl;
      logic [OutW-1:0]   rdy_seq [3];
      logic              rdy_exp [3];
      rdy_seq = '{2'b00, 2'b11, 2'b11};
      rdy_exp = '{1'b0, 1'b0, 1'b1};
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b00, 1'b0);
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b00, 1'b0);
      checks++;
      if (dut.cnt_q !== 4'd8) begin errors++; $display("FAIL fill_cnt got=%0d exp=8", dut.cnt_q); end
      // third beat stays stalled while nothing drains, then re-opens at 4 free
      for (int c = 0; c < 3; c++) begin
         fresh(pl); drive(1'b1, 4'hF, pl, rdy_seq[c], 1'b0);
         checks++;
         if (bus.in_rdy_o !== rdy_exp[c]) begin
            errors++;
            $display("FAIL stall_rdy%0d got=%b exp=%b", c, bus.in_rdy_o, rdy_exp[c]);
         end
      end
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b11, 1'b0);
      checks++;
      if (dut.cnt_q !== 4'd6) begin errors++; $display("FAIL stall_accept_cnt got=%0d exp=6", dut.cnt_q); end
      repeat (4) drive(1'b0, '0, '0, 2'b11, 1'b0);
      checks++;
      if (bus.out_vld_o !== 2'b00) begin errors++; $display("FAIL fill_drained got=%b exp=00", bus.out_vld_o); end
   endtask

   task automatic test_wrap();
      logic [InW*DW-1:0] pl;
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b00, 1'b0);
      fresh(pl); drive(1'b1, 4'b0111, pl, 2'b00, 1'b0);
      checks++;
      if (dut.cnt_q !== 4'd7) begin errors++; $display("FAIL wrap_preload got=%0d exp=7", dut.cnt_q); end
      for (int c = 0; c < 16; c++) begin
         fresh(pl);
         drive(1'b1, 4'b0111, pl, (c % 2 == 1) ? 2'b11 : 2'b01, 1'b0);
      end
      repeat (8) drive(1'b0, '0, '0, 2'b11, 1'b0);
      checks++;
      if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL wrap_drained got=%0d exp=0", dut.cnt_q); end
   endtask

   task automatic test_simultaneous();
      logic [InW*DW-1:0] pl;
      logic [2:0] h;
      logic [2:0] t;
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b00, 1'b0);
      h = dut.head_q + 3'd2;
      t = dut.tail_q + 3'd3;
      fresh(pl); drive(1'b1, 4'b0111, pl, 2'b11, 1'b0);
      checks++;
      if (dut.cnt_q !== 4'd5) begin errors++; $display("FAIL simul_cnt got=%0d exp=5", dut.cnt_q); end
      checks++;
      if (dut.head_q !== h) begin errors++; $display("FAIL simul_head got=%0d exp=%0d", dut.head_q, h); end
      checks++;
      if (dut.tail_q !== t) begin errors++; $display("FAIL simul_tail got=%0d exp=%0d", dut.tail_q, t); end
      checks++;
      if (bus.in_rdy_o !== 1'b0) begin errors++; $display("FAIL simul_rdy got=%b exp=0", bus.in_rdy_o); end
      repeat (4) drive(1'b0, '0, '0, 2'b11, 1'b0);
   endtask

   task automatic test_flush();
      logic [InW*DW-1:0] pl;
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b00, 1'b0);
      fresh(pl); drive(1'b1, 4'b0011, pl, 2'b00, 1'b0);
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b11, 1'b1);
      checks++;
      if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL flush6_cnt got=%0d exp=0", dut.cnt_q); end
      checks++;
      if (bus.out_vld_o !== 2'b00) begin errors++; $display("FAIL flush6_vld got=%b exp=00", bus.out_vld_o); end
      checks++;
      if (bus.in_rdy_o !== 1'b1) begin errors++; $display("FAIL flush6_rdy got=%b exp=1", bus.in_rdy_o); end
      // flush while the input beat genuinely fires
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b00, 1'b0);
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b11, 1'b1);
      checks++;
      if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL flush4_cnt got=%0d exp=0", dut.cnt_q); end
      repeat (2) drive(1'b0, '0, '0, 2'b11, 1'b0);
      checks++;
      if (bus.out_vld_o !== 2'b00) begin errors++; $display("FAIL flush_stays_empty got=%b exp=00", bus.out_vld_o); end
   endtask

   task automatic test_random();
      logic [InW*DW-1:0] pl;
      logic [OutW-1:0]   rdy;
      logic [InW-1:0]    mask;
      for (int c = 0; c < 10000; c++) begin
         for (int l = 0; l < InW; l++) pl[l*DW +: DW] = $urandom;
         mask = 4'($urandom);
         case ($urandom_range(0, 2))
            0:       rdy = 2'b00;
            1:       rdy = 2'b01;
            default: rdy = 2'b11;
         endcase
         drive($urandom_range(0, 3) != 0, mask, pl, rdy, $urandom_range(0, 63) == 0);
      end
      repeat (8) drive(1'b0, '0, '0, 2'b11, 1'b0);
      checks++;
      if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL random_drained got=%0d exp=0", dut.cnt_q); end
   endtask

   task automatic test_mid_reset();
      logic [InW*DW-1:0] pl;
      fresh(pl); drive(1'b1, 4'hF, pl, 2'b00, 1'b0);
      bus.in_vld_i = 1'b0;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (bus.out_vld_o !== 2'b00) begin errors++; $display("FAIL midrst_vld got=%b exp=00", bus.out_vld_o); end
      checks++;
      if (bus.in_rdy_o !== 1'b1) begin errors++; $display("FAIL midrst_rdy got=%b exp=1", bus.in_rdy_o); end
      @(posedge clk);
      #1 rstn = 1'b1;
      fresh(pl); drive(1'b1, 4'b1001, pl, 2'b00, 1'b0);
      checks++;
      if (bus.out_vld_o !== 2'b11) begin errors++; $display("FAIL midrst_resume got=%b exp=11", bus.out_vld_o); end
      repeat (2) drive(1'b0, '0, '0, 2'b11, 1'b0);
   endtask

   initial begin
      bus.in_vld_i     = 1'b0;
      bus.in_mask_i    = '0;
      bus.in_payload_i = '0;
      bus.out_rdy_i    = '0;
      bus.flush_i      = 1'b0;
      #1;
      test_reset();
      test_pass_through();
      test_fill_to_stall();
      test_wrap();
      test_simultaneous();
      test_flush();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
